// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package hazard_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] RES_LOAD = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fp_state_t;

    // Same register in the same file; integer x0 never matches, FP f0 does.
    function automatic logic reg_match(input logic [4:0] a, input logic fa,
                                       input logic [4:0] d, input logic fd);
        return (a == d) && (fa == fd) && (fa || (d != 5'd0));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; optional HAZARD_PERF_EN adds perf counters.
// Latency: n/a (wires only).
// Backpressure: n/a; stall/flush lines are the backpressure of the pipeline itself.
interface hazard_ctrl_if;
    logic [4:0] Rs1D, Rs2D;
    logic       FPsrcD;
    logic [4:0] Rs1E, Rs2E, RdE;
    logic       FPsrcE, FPdstE;
    logic [1:0] ResultSrcE;
    logic       FPAluE;
    logic       PCSrcE;
    logic [4:0] RdM, RdW;
    logic       RegWriteM, RegWriteW;
    logic       FPdstM, FPdstW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE;
    logic       FlushD, FlushE, FlushM;
    logic       FPBusy;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCnt, FlushCnt;
`endif

    modport master (
`ifdef HAZARD_PERF_EN
        input  StallCnt, FlushCnt,
`endif
        output Rs1D, Rs2D, FPsrcD, Rs1E, Rs2E, RdE, FPsrcE, FPdstE,
               ResultSrcE, FPAluE, PCSrcE, RdM, RdW, RegWriteM, RegWriteW,
               FPdstM, FPdstW,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, FPBusy
    );

    modport slave (
`ifdef HAZARD_PERF_EN
        output StallCnt, FlushCnt,
`endif
        input  Rs1D, Rs2D, FPsrcD, Rs1E, Rs2E, RdE, FPsrcE, FPdstE,
               ResultSrcE, FPAluE, PCSrcE, RdM, RdW, RegWriteM, RegWriteW,
               FPdstM, FPdstW,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, FPBusy
    );
endinterface

// File: rtl/hazard_ctrl_fp_busy_fsm.sv
// Keeps a multi-cycle FP ALU op resident in EX for FP_LAT cycles (IDLE -> BUSY -> DONE).
// Latency: fp_stall is combinational from state and fp_alu; state updates each clk.
// Backpressure: fp_stall holds F/D/E and bubbles EX/MEM; forced low while reset is high.
module fp_busy_fsm
    import hazard_pkg::*;
#(
    parameter int FP_LAT = 4,
    parameter int CNT_W  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic fp_alu,
    output logic busy,
    output logic fp_stall
);

    localparam logic MULTI = (FP_LAT > 1);

    fp_state_t          state;
    logic [CNT_W-1:0]   cnt;

    // State and down-counter; cycle 1 is spent in IDLE, the last one in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fp_alu && FP_LAT == 2) begin
                        state <= DONE;
                    end else if (fp_alu && FP_LAT > 2) begin
                        state <= BUSY;
                        cnt   <= CNT_W'(FP_LAT - 3);
                    end
                end
                BUSY: begin
                    if (cnt == '0) state <= DONE;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                DONE:    state <= IDLE;   // finishing op still in E: ignore fp_alu
                default: state <= IDLE;
            endcase
        end
    end

    // Stall while the op still needs more EX cycles; DONE releases the pipe.
    always_comb begin
        busy     = !reset && (state != IDLE);
        fp_stall = !reset && (((state == IDLE) && fp_alu && MULTI) || (state == BUSY));
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: operand forwarding, load-use and FP multi-cycle stalls, branch flushes.
// Latency: all outputs combinational from inputs and FSM state; optional HAZARD_PERF_EN counters are registered.
// Backpressure: issues StallF/D/E and FlushD/E/M; fpStall masks lwStall and branch flushes.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FP_LAT = 4,
    parameter int CNT_W  = 4
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz
);

    logic fp_stall;
    logic fp_busy;
    logic lw_stall;

    fp_busy_fsm #(.FP_LAT(FP_LAT), .CNT_W(CNT_W)) u_fp_busy (
        .clk      (clk),
        .reset    (reset),
        .fp_alu   (hz.FPAluE),
        .busy     (fp_busy),
        .fp_stall (fp_stall)
    );

    // Forwarding select; M is younger than W so it wins. Load-use detect against E.
    always_comb begin
        hz.ForwardAE = FWD_RF;
        hz.ForwardBE = FWD_RF;
        if (hz.RegWriteM && reg_match(hz.Rs1E, hz.FPsrcE, hz.RdM, hz.FPdstM))
            hz.ForwardAE = FWD_M;
        else if (hz.RegWriteW && reg_match(hz.Rs1E, hz.FPsrcE, hz.RdW, hz.FPdstW))
            hz.ForwardAE = FWD_W;
        if (hz.RegWriteM && reg_match(hz.Rs2E, hz.FPsrcE, hz.RdM, hz.FPdstM))
            hz.ForwardBE = FWD_M;
        else if (hz.RegWriteW && reg_match(hz.Rs2E, hz.FPsrcE, hz.RdW, hz.FPdstW))
            hz.ForwardBE = FWD_W;
        if (reset) begin
            hz.ForwardAE = FWD_RF;
            hz.ForwardBE = FWD_RF;
        end
        lw_stall = !reset && (hz.ResultSrcE == RES_LOAD) &&
                   (reg_match(hz.Rs1D, hz.FPsrcD, hz.RdE, hz.FPdstE) ||
                    reg_match(hz.Rs2D, hz.FPsrcD, hz.RdE, hz.FPdstE));
    end

    // Stall/flush combine; an FP stall already holds D, so it masks load-use and branch flushes.
    always_comb begin
        hz.StallF = lw_stall || fp_stall;
        hz.StallD = lw_stall || fp_stall;
        hz.StallE = fp_stall;
        hz.FlushM = fp_stall;
        hz.FlushD = !reset && hz.PCSrcE && !fp_stall;
        hz.FlushE = !reset && (lw_stall || hz.PCSrcE) && !fp_stall;
        hz.FPBusy = fp_busy;
    end

`ifdef HAZARD_PERF_EN
    // Free-running stall / front-end flush counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hz.StallCnt <= '0;
            hz.FlushCnt <= '0;
        end else begin
            if (hz.StallF) hz.StallCnt <= hz.StallCnt + 32'd1;
            if (hz.FlushD) hz.FlushCnt <= hz.FlushCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with FP_LAT = 4; covers HAZARD_PERF_EN when defined.
// Latency: checks are taken 1ns after the falling edge, inputs driven on the falling edge.
// Backpressure: n/a.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    hazard_ctrl_if hz();

    hazard_ctrl #(.FP_LAT(4), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.FPsrcD = 1'b0;
        hz.Rs1E = 5'd0; hz.Rs2E = 5'd0; hz.RdE = 5'd0;
        hz.FPsrcE = 1'b0; hz.FPdstE = 1'b0;
        hz.ResultSrcE = 2'b00; hz.FPAluE = 1'b0; hz.PCSrcE = 1'b0;
        hz.RdM = 5'd0; hz.RdW = 5'd0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        hz.FPdstM = 1'b0; hz.FPdstW = 1'b0;
    endtask

    // Packs {StallF,StallD,StallE,FlushD,FlushE,FlushM,FPBusy}.
    function automatic logic [6:0] ctl();
        return {hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushM, hz.FPBusy};
    endfunction

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        // Hazards present while in reset: every output must stay 0.
        hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1;
        hz.PCSrcE = 1'b1; hz.FPAluE = 1'b1;
        #1;
        check("rst_fwdA", {30'd0, hz.ForwardAE}, 32'd0);
        check("rst_ctl",  {25'd0, ctl()}, 32'd0);
        #11 reset = 1'b0;
        clear_inputs();

        // Forwarding priority: M over W.
        next_cycle();
        hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1;
        hz.RdW = 5'd5; hz.RegWriteW = 1'b1;
        #1 check("fwd_m_prio", {30'd0, hz.ForwardAE}, 32'h2);
        check("fwd_m_nostall", {25'd0, ctl()}, 32'd0);
        hz.RegWriteM = 1'b0;
        #1 check("fwd_w", {30'd0, hz.ForwardAE}, 32'h1);
        hz.Rs2E = 5'd5;
        #1 check("fwd_b_w", {30'd0, hz.ForwardBE}, 32'h1);

        // x0 never forwards; f0 does.
        next_cycle();
        clear_inputs();
        hz.RdM = 5'd0; hz.Rs1E = 5'd0; hz.RegWriteM = 1'b1;
        #1 check("fwd_x0", {30'd0, hz.ForwardAE}, 32'h0);
        hz.FPsrcE = 1'b1; hz.FPdstM = 1'b1;
        #1 check("fwd_f0", {30'd0, hz.ForwardAE}, 32'h2);

        // Domain mismatch: FP dest f3 vs integer x3.
        next_cycle();
        clear_inputs();
        hz.RdM = 5'd3; hz.FPdstM = 1'b1; hz.RegWriteM = 1'b1;
        hz.Rs2E = 5'd3; hz.FPsrcE = 1'b0;
        #1 check("fwd_domain", {30'd0, hz.ForwardBE}, 32'h0);

        // Load-use on Rs2D.
        next_cycle();
        clear_inputs();
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
        #1 check("lw_ctl", {25'd0, ctl()}, 32'b1100100);
        next_cycle();
        clear_inputs();
        #1 check("lw_clear", {25'd0, ctl()}, 32'd0);

        // Taken branch alone.
        next_cycle();
        hz.PCSrcE = 1'b1;
        #1 check("br_ctl", {25'd0, ctl()}, 32'b0001100);
        next_cycle();
        clear_inputs();

        // FP op, FP_LAT = 4: stalls cycles 1-3, FPBusy cycles 2-4.
        next_cycle();
        hz.FPAluE = 1'b1;
        #1 check("fp_c1", {25'd0, ctl()}, 32'b1110010);
        next_cycle();
        #1 check("fp_c2", {25'd0, ctl()}, 32'b1110011);
        next_cycle();
        #1 check("fp_c3", {25'd0, ctl()}, 32'b1110011);
        next_cycle();
        #1 check("fp_c4", {25'd0, ctl()}, 32'b0000001);
        next_cycle();
        hz.FPAluE = 1'b0;
        #1 check("fp_c5", {25'd0, ctl()}, 32'd0);

        // Same with a branch in cycle 1: stall wins, flushes masked; load-use masked too.
        next_cycle();
        hz.FPAluE = 1'b1; hz.PCSrcE = 1'b1;
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd9; hz.Rs1D = 5'd9;
        #1 check("fpbr_c1", {25'd0, ctl()}, 32'b1110010);
        next_cycle();
        clear_inputs(); hz.FPAluE = 1'b1;
        #1 check("fpbr_c2", {25'd0, ctl()}, 32'b1110011);
        next_cycle();
        next_cycle();
        #1 check("fpbr_c4", {25'd0, ctl()}, 32'b0000001);
        next_cycle();
        hz.FPAluE = 1'b0;
        #1 check("fpbr_c5", {25'd0, ctl()}, 32'd0);

        // Reset while BUSY: outputs drop without a clock edge.
        next_cycle();
        hz.FPAluE = 1'b1;
        next_cycle();
        hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.PCSrcE = 1'b1;
        #1 check("busy_before_rst", {25'd0, ctl()}, 32'b1110011);
        #1 reset = 1'b1;
        #1 check("rst_busy_ctl", {25'd0, ctl()}, 32'd0);
        check("rst_busy_fwd", {30'd0, hz.ForwardAE}, 32'd0);
        next_cycle();
        reset = 1'b0;
        clear_inputs();
        #1 check("post_rst_idle", {25'd0, ctl()}, 32'd0);

`ifdef HAZARD_PERF_EN
        check("perf_stall_rst", hz.StallCnt, 32'd0);
        check("perf_flush_rst", hz.FlushCnt, 32'd0);
        next_cycle();
        hz.FPAluE = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        next_cycle();
        hz.FPAluE = 1'b0;
        #1 check("perf_stall_fp", hz.StallCnt, 32'd3);
        check("perf_flush_fp", hz.FlushCnt, 32'd0);
        hz.PCSrcE = 1'b1;
        next_cycle();
        hz.PCSrcE = 1'b0;
        #1 check("perf_flush_br", hz.FlushCnt, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipelined RISC-V core with FP extensions.
- Consumes the decode/execute register's E-stage outputs plus the M- and W-stage destination tags.
- Drives that register's clr (FlushE) and the pipeline stall and flush controls.
- Holds a small FSM that keeps a multi-cycle FP ALU operation in EX for FP_LAT cycles.

Parameters:
- FP_LAT, 4, total EX-stage residency in cycles of an FPAluE instruction (legal 1..16).
- CNT_W, 4, width of the FP busy down-counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- Rs1D, Rs2D  in  5  D-stage source registers
- FPsrcD  in  1  D-stage sources read the FP register file
- Rs1E, Rs2E, RdE  in  5  E-stage source and destination registers
- FPsrcE, FPdstE  in  1  E-stage source / destination register-file select (1 = FP)
- ResultSrcE  in  2  2'b01 = load in E
- FPAluE  in  1  multi-cycle FP op in E
- PCSrcE  in  1  taken branch or jump resolved in E
- RdM, RdW  in  5  M- and W-stage destinations
- RegWriteM, RegWriteW  in  1  M- and W-stage write enables
- FPdstM, FPdstW  in  1  M- and W-stage destination file select
- ForwardAE, ForwardBE  out  2  operand mux select: 00 = register file, 10 = ALUResultM, 01 = ResultW
- StallF, StallD, StallE  out  1  hold PC, IF/ID, ID/EX
- FlushD, FlushE, FlushM  out  1  bubble into IF/ID, ID/EX (clr), EX/MEM
- FPBusy  out  1  FSM not IDLE

Behaviour:
- Registered state is the FSM (IDLE, BUSY, DONE) and the counter cnt. All outputs are combinational from state and inputs.
- Reset state: IDLE, cnt = 0. Under reset (async, immediate), every output is 0 regardless of inputs.
- Register match rule, match(a, fa, d, fd): a == d and fa == fd.
  - If fa = 0 (integer file), d != 0 is additionally required.
  - FP register f0 is a real register and is forwarded.
- Forwarding, ForwardAE (ForwardBE identical with Rs2E):
  - 10 if RegWriteM and match(Rs1E, FPsrcE, RdM, FPdstM).
  - else 01 if RegWriteW and match(Rs1E, FPsrcE, RdW, FPdstW).
  - else 00. M has priority over W.
- lwStall = (ResultSrcE == 01) and (match(Rs1D, FPsrcD, RdE, FPdstE) or match(Rs2D, FPsrcD, RdE, FPdstE)).
- fpStall = (IDLE and FPAluE and FP_LAT > 1) or BUSY.
- Outputs:
  - StallF = StallD = lwStall or fpStall.
  - StallE = FlushM = fpStall.
  - FlushD = PCSrcE and not fpStall.
  - FlushE = (lwStall or PCSrcE) and not fpStall.
- FSM transitions:
  - IDLE, FPAluE, FP_LAT == 2: go to DONE.
  - IDLE, FPAluE, FP_LAT > 2: go to BUSY, cnt <= FP_LAT-3.
  - IDLE, FP_LAT == 1: stay IDLE, no stall.
  - BUSY: cnt == 0 goes to DONE, else cnt decrements.
  - DONE: go to IDLE unconditionally. FPAluE is ignored because the finishing instruction is still visible in E. No stall in DONE.
- Result: the FP instruction occupies EX for exactly FP_LAT cycles. EX/MEM receives bubbles during stalls.
- Simultaneous events:
  - PCSrcE together with FPAluE in IDLE: stall wins, and the branch flush is masked for that cycle.
  - lwStall during fpStall is masked, because D is already held.
- Reset mid-BUSY: immediately IDLE, with all stalls and flushes deasserted.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined:
  - Adds outputs StallCnt[31:0] and FlushCnt[31:0], both reset to 0.
  - StallCnt increments each cycle StallF = 1. FlushCnt increments each cycle FlushD = 1.
  - Both counters wrap at 2^32.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - RES_LOAD = 2'b01.
  - FSM state encoding: IDLE = 0, BUSY = 1, DONE = 2.
- Sub-module fp_busy_fsm contains the state, the counter and FPBusy/fpStall generation. Forwarding and load-use logic stay in the top module.

Test Plan:
- Forwarding priority:
  - Rs1E = 5, RdM = 5, RegWriteM = 1, RdW = 5, RegWriteW = 1, all domains integer -> ForwardAE = 10.
  - Drop RegWriteM -> ForwardAE = 01.
- Domain and x0:
  - RdM = 0, integer, RegWriteM = 1, Rs1E = 0 -> ForwardAE = 00.
  - Same with FPsrcE = FPdstM = 1 -> ForwardAE = 10.
  - RdM = 3 with FPdstM = 1 against integer Rs2E = 3 -> ForwardBE = 00.
- Load-use: ResultSrcE = 01, RdE = 7, Rs2D = 7, integer -> StallF = StallD = FlushE = 1 for one cycle, FlushD = 0.
- Branch: PCSrcE = 1, no other hazard -> FlushD = FlushE = 1, no stalls.
- FP_LAT = 4: FPAluE held with E stalled -> StallE = FlushM = 1 for exactly 3 cycles, FPBusy = 1 on cycles 2-4, then IDLE. Repeat with PCSrcE = 1 on cycle 1 -> FlushD = 0.
- Reset in BUSY (cycle 2) -> state IDLE and all outputs 0 immediately, without waiting for a clock edge. With HAZARD_PERF_EN defined, StallCnt = 0 after reset and equals 3 after the full FP sequence.
